// File: rtl/iterative_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// master = pipeline side, slave = the unit.
interface iterative_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, abort,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, abort,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; done WIDTH/BPC+1 edges after launch.
// No backpressure: busy stalls the pipeline, starts while busy are dropped, abort flushes.
module iterative_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  iterative_muldiv_unit_if.slave bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;

  // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    shifted  = '0;
    for (int i = 0; i < BPC; i++) begin
      if (is_div_q) begin
        shifted = {acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1]};
        if (shifted >= {1'b0, opa_q}) begin
          shifted  = shifted - {1'b0, opa_q};
          acc_step = {shifted[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b1};
        end else begin
          acc_step = {shifted[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, opa_q} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end
    end
  end

  logic               sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opa_d     = opa_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    sgn_op   = ~bus.op[0];
    rs_neg   = sgn_op & bus.rs_data[WIDTH-1];
    rt_neg   = sgn_op & bus.rt_data[WIDTH-1];
    rs_abs   = rs_neg ? -bus.rs_data : bus.rs_data;
    rt_abs   = rt_neg ? -bus.rt_data : bus.rt_data;
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          case (bus.op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              if (bus.op[1] && bus.rt_data == '0) begin
                hi_d   = bus.rs_data;
                lo_d   = '1;
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                state_d   = S_RUN;
                busy_d    = 1'b1;
                cnt_d     = CW'(N);
                is_div_d  = bus.op[1];
                neg_d     = rs_neg ^ rt_neg;
                neg_rem_d = rs_neg;
                opa_d     = bus.op[1] ? rt_abs : rs_abs;
                acc_d     = {{WIDTH{1'b0}}, bus.op[1] ? rs_abs : rt_abs};
              end
            end
            3'b100: begin
              hi_d   = bus.rs_data;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = bus.rs_data;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!bus.abort) begin
          hi_d   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opa_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opa_q     <= opa_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed bench: unit1 runs BPC=1, unit2 (BPC=4) mirrors unit1's inputs.
module tb_iterative_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   lat1, lat2, busy1, dbz1, done_cnt;

  always #5 clk = ~clk;

  iterative_muldiv_unit_if #(.WIDTH(32)) bus1 ();
  iterative_muldiv_unit_if #(.WIDTH(32)) bus2 ();

  assign bus2.start   = bus1.start;
  assign bus2.op      = bus1.op;
  assign bus2.rs_data = bus1.rs_data;
  assign bus2.rt_data = bus1.rt_data;
  assign bus2.abort   = bus1.abort;

  iterative_muldiv_unit #(.WIDTH(32), .BPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  iterative_muldiv_unit #(.WIDTH(32), .BPC(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one request at the next edge, then wait up to maxk cycles for unit1's done.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic ab, input int maxk);
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = o; bus1.rs_data = a; bus1.rt_data = b; bus1.abort = ab;
    @(negedge clk);
    bus1.start = 1'b0; bus1.abort = 1'b0;
    lat1 = -1; lat2 = -1; busy1 = 0; dbz1 = 0;
    for (int k = 0; k < maxk; k++) begin
      if (bus1.busy) busy1++;
      if (bus2.done && lat2 < 0) lat2 = k;
      if (bus1.done) begin
        lat1 = k;
        dbz1 = int'(bus1.div_by_zero);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_pulse_end(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, 64'(bus1.done), 64'd0);
    chk({tag, "_dbz_low"}, 64'(bus1.div_by_zero), 64'd0);
  endtask

  initial begin
    bus1.start = 1'b0; bus1.op = 3'b000; bus1.rs_data = '0; bus1.rt_data = '0; bus1.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(bus1.hi), 64'd0);
    chk("rst_lo", 64'(bus1.lo), 64'd0);
    chk("rst_busy", 64'(bus1.busy), 64'd0);
    chk("rst_done", 64'(bus1.done), 64'd0);
    chk("rst_dbz", 64'(bus1.div_by_zero), 64'd0);
    rst = 1'b1;

    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 100);
    chk("multu_lat", 64'(lat1), 64'(33));
    chk("multu_busy_cycles", 64'(busy1), 64'(33));
    chk("multu_busy_at_done", 64'(bus1.busy), 64'd0);
    chk("multu_hi", 64'(bus1.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus1.lo), 64'h0000_0001);
    chk("multu_dbz", 64'(dbz1), 64'd0);
    chk_pulse_end("multu");

    run(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0, 100);
    chk("mult_lat", 64'(lat1), 64'(33));
    chk("mult_hi", 64'(bus1.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus1.lo), 64'hFFFF_FFEB);
    chk("mult_bpc4_lat", 64'(lat2), 64'(9));
    chk("mult_bpc4_hi", 64'(bus2.hi), 64'hFFFF_FFFF);
    chk("mult_bpc4_lo", 64'(bus2.lo), 64'hFFFF_FFEB);

    run(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 100);
    chk("div_lat", 64'(lat1), 64'(33));
    chk("div_lo", 64'(bus1.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus1.hi), 64'hFFFF_FFFF);

    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 100);
    chk("divovf_lo", 64'(bus1.lo), 64'h8000_0000);
    chk("divovf_hi", 64'(bus1.hi), 64'h0);
    chk("divovf_dbz", 64'(dbz1), 64'd0);

    run(3'b011, 32'd100, 32'd7, 1'b0, 100);
    chk("divu_lo", 64'(bus1.lo), 64'd14);
    chk("divu_hi", 64'(bus1.hi), 64'd2);

    run(3'b011, 32'd100, 32'd0, 1'b0, 100);
    chk("dbz_lat", 64'(lat1), 64'(0));
    chk("dbz_flag", 64'(dbz1), 64'd1);
    chk("dbz_busy_cycles", 64'(busy1), 64'(0));
    chk("dbz_hi", 64'(bus1.hi), 64'h0000_0064);
    chk("dbz_lo", 64'(bus1.lo), 64'hFFFF_FFFF);
    chk_pulse_end("dbz");

    run(3'b100, 32'h0000_1234, 32'd0, 1'b0, 100);
    chk("mthi_lat", 64'(lat1), 64'(0));
    chk("mthi_hi", 64'(bus1.hi), 64'h0000_1234);
    chk("mthi_lo_kept", 64'(bus1.lo), 64'hFFFF_FFFF);
    chk("mthi_busy", 64'(busy1), 64'(0));
    chk_pulse_end("mthi");

    run(3'b110, 32'hDEAD_BEEF, 32'd1, 1'b0, 40);
    chk("inval_no_done", 64'(lat1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("inval_busy", 64'(busy1), 64'(0));
    chk("inval_hi", 64'(bus1.hi), 64'h0000_1234);

    run(3'b001, 32'd5, 32'd6, 1'b1, 40);
    chk("abort_start_no_done", 64'(lat1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("abort_start_busy", 64'(busy1), 64'(0));

    // MULT in flight, ignored MTLO at cycle 5, abort at cycle 10
    done_cnt = 0;
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 3'b000; bus1.rs_data = 32'd5; bus1.rt_data = 32'd6;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      if (bus1.done) done_cnt++;
    end
    bus1.start = 1'b1; bus1.op = 3'b101; bus1.rs_data = 32'h55;
    @(negedge clk);
    bus1.start = 1'b0;
    if (bus1.done) done_cnt++;
    for (int k = 6; k < 10; k++) begin
      @(negedge clk);
      if (bus1.done) done_cnt++;
    end
    chk("abort_busy_before", 64'(bus1.busy), 64'd1);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    chk("abort_busy_after", 64'(bus1.busy), 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (bus1.done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_hi", 64'(bus1.hi), 64'h0000_1234);
    chk("abort_lo", 64'(bus1.lo), 64'hFFFF_FFFF);

    run(3'b101, 32'h55, 32'd0, 1'b0, 100);
    chk("mtlo_lat", 64'(lat1), 64'(0));
    chk("mtlo_lo", 64'(bus1.lo), 64'h55);
    chk("mtlo_hi_kept", 64'(bus1.hi), 64'h0000_1234);
    chk_pulse_end("mtlo");

    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 3'b011; bus1.rs_data = 32'd1000; bus1.rt_data = 32'd3;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_hi", 64'(bus1.hi), 64'd0);
    chk("midrst_lo", 64'(bus1.lo), 64'd0);
    chk("midrst_busy", 64'(bus1.busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run(3'b001, 32'd2, 32'd3, 1'b0, 100);
    chk("postrst_lat", 64'(lat1), 64'(33));
    chk("postrst_lo", 64'(bus1.lo), 64'd6);
    chk("postrst_hi", 64'(bus1.hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
